// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares one single-port RAM between instruction fetch and load/store.
// Alternating-priority grant, fixed-latency access, one-cycle ready pulse per access.
module mem_port_arbiter #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [1:0]        ram_size,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_MEM  = 1'b1;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                grant_mem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      last_q      <= OWN_IF;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    // On a tie MEM wins only if IF was served last.
    grant_mem   = mem_req && (!if_req || (last_q == OWN_IF));
    case (state_q)
      IDLE: begin
        if (mem_req || if_req) begin
          owner_d = grant_mem;
          last_d  = grant_mem;
          cnt_d   = '0;
          state_d = BUSY;
          if (grant_mem) begin
            addr_d  = mem_addr;
            we_d    = mem_we;
            size_d  = mem_size;
            wdata_d = mem_wdata;
          end else begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            size_d  = 2'b10;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q == OWN_MEM) mem_rdata_d = ram_rdata;
            else                    if_rdata_d  = ram_rdata;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign if_ready  = (state_q == DONE) && (owner_q == OWN_IF);
  assign mem_ready = (state_q == DONE) && (owner_q == OWN_MEM);
  assign if_stall  = if_req && !if_ready;
  assign mem_stall = mem_req && !mem_ready;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_en    = (state_q == BUSY);
  assign ram_we    = (state_q == BUSY) && we_q;
  assign ram_size  = size_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: directed checks of arbitration, latency, reset abort and data return.
// Two instances: WAIT_CYCLES=1 (a_*) and WAIT_CYCLES=3 (b_*), sharing requester inputs.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        init;
  logic        if_req;
  logic [8:0]  if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;

  logic [31:0] a_if_rdata, a_mem_rdata, a_ram_wdata, a_ram_rdata;
  logic        a_if_ready, a_if_stall, a_mem_ready, a_mem_stall, a_ram_en, a_ram_we;
  logic [1:0]  a_ram_size;
  logic [8:0]  a_ram_addr;
  logic [31:0] b_if_rdata, b_mem_rdata, b_ram_wdata, b_ram_rdata;
  logic        b_if_ready, b_if_stall, b_mem_ready, b_mem_stall, b_ram_en, b_ram_we;
  logic [1:0]  b_ram_size;
  logic [8:0]  b_ram_addr;

  logic [31:0] ram [0:127];
  int n_checks;
  int n_fail;

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata),
    .if_ready(a_if_ready), .if_stall(a_if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(a_mem_rdata),
    .mem_ready(a_mem_ready), .mem_stall(a_mem_stall),
    .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_size(a_ram_size),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata),
    .if_ready(b_if_ready), .if_stall(b_if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(b_mem_rdata),
    .mem_ready(b_mem_ready), .mem_stall(b_mem_stall),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_size(b_ram_size),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  // Word-wide RAM model; only dut_a's stores land in it.
  always @(posedge clk) begin
    if (init) begin
      ram[1] <= 32'h8C22_0000;
      ram[4] <= 32'h0000_0000;
      ram[8] <= 32'h1111_1111;
      ram[9] <= 32'h2222_2222;
    end else if (a_ram_en && a_ram_we) begin
      ram[a_ram_addr[8:2]] <= a_ram_wdata;
    end
  end
  assign a_ram_rdata = ram[a_ram_addr[8:2]];
  assign b_ram_rdata = ram[b_ram_addr[8:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    init      = 1'b1;
    if_req    = 1'b0;
    if_addr   = 9'h000;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_size  = 2'b00;
    mem_addr  = 9'h000;
    mem_wdata = 32'h0;
    tick();
    tick();

    // Reset state
    chk ("rst_if_rdata",  a_if_rdata, 32'h0);
    chk ("rst_mem_rdata", a_mem_rdata, 32'h0);
    chkb("rst_ram_en",    a_ram_en, 1'b0);
    chk ("rst_ram_addr",  32'(a_ram_addr), 32'h0);
    chkb("rst_if_ready",  a_if_ready, 1'b0);
    if_req = 1'b1;
    #1;
    chkb("rst_if_stall",  a_if_stall, 1'b1);
    if_req = 1'b0;
    #1;
    chkb("rst_if_stall0", a_if_stall, 1'b0);
    reset_n = 1'b1;
    init    = 1'b0;

    // Fetch of 0x004 with 1-cycle latency
    if_req  = 1'b1;
    if_addr = 9'h004;
    #1;
    chkb("f_stall_t",   a_if_stall, 1'b1);
    chkb("f_en_t",      a_ram_en, 1'b0);
    tick();
    chkb("f_en_t1",     a_ram_en, 1'b1);
    chk ("f_addr_t1",   32'(a_ram_addr), 32'h004);
    chk ("f_size_t1",   32'(a_ram_size), 32'd2);
    chkb("f_we_t1",     a_ram_we, 1'b0);
    chkb("f_stall_t1",  a_if_stall, 1'b1);
    chkb("f_ready_t1",  a_if_ready, 1'b0);
    tick();
    chkb("f_ready_t2",  a_if_ready, 1'b1);
    chk ("f_rdata_t2",  a_if_rdata, 32'h8C22_0000);
    chkb("f_stall_t2",  a_if_stall, 1'b0);
    chkb("f_en_t2",     a_ram_en, 1'b0);
    tick();
    chkb("f_ready_t3",  a_if_ready, 1'b0);
    chkb("f_en_t3",     a_ram_en, 1'b0);
    if_req = 1'b0;

    // Store 0xDEADBEEF to 0x010, then load it back
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_size  = 2'b10;
    mem_addr  = 9'h010;
    mem_wdata = 32'hDEAD_BEEF;
    tick();
    chkb("s_en",        a_ram_en, 1'b1);
    chkb("s_we",        a_ram_we, 1'b1);
    chk ("s_addr",      32'(a_ram_addr), 32'h010);
    chk ("s_wdata",     a_ram_wdata, 32'hDEAD_BEEF);
    tick();
    chkb("s_ready",     a_mem_ready, 1'b1);
    chkb("s_we_done",   a_ram_we, 1'b0);
    chk ("s_rdata_keep", a_mem_rdata, 32'h0);
    tick();
    mem_we = 1'b0;
    tick();
    chkb("l_we",        a_ram_we, 1'b0);
    chkb("l_en",        a_ram_en, 1'b1);
    tick();
    chkb("l_ready",     a_mem_ready, 1'b1);
    chk ("l_rdata",     a_mem_rdata, 32'hDEAD_BEEF);
    tick();
    mem_req = 1'b0;

    // Contention held from reset: MEM, IF, MEM, IF every 3 cycles
    reset_n  = 1'b0;
    if_req   = 1'b1;
    if_addr  = 9'h004;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 9'h010;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chkb("c_en_busy", a_ram_en, 1'b1);
      chk ("c_addr",    32'(a_ram_addr), (k % 2 == 0) ? 32'h010 : 32'h004);
      tick();
      chkb("c_mem_ready", a_mem_ready, (k % 2 == 0));
      chkb("c_if_ready",  a_if_ready,  (k % 2 == 1));
      tick();
      chkb("c_en_idle", a_ram_en, 1'b0);
      chkb("c_mready0", a_mem_ready, 1'b0);
      chkb("c_iready0", a_if_ready, 1'b0);
    end
    chk ("c_mem_rdata", a_mem_rdata, 32'hDEAD_BEEF);
    chk ("c_if_rdata",  a_if_rdata, 32'h8C22_0000);
    if_req  = 1'b0;
    mem_req = 1'b0;
    tick();

    // Back-to-back loads 0x020 then 0x024
    mem_req  = 1'b1;
    mem_addr = 9'h020;
    tick();
    chk ("bb_addr0",   32'(a_ram_addr), 32'h020);
    tick();
    chkb("bb_ready0",  a_mem_ready, 1'b1);
    chk ("bb_rdata0",  a_mem_rdata, 32'h1111_1111);
    tick();
    chkb("bb_ready_gap", a_mem_ready, 1'b0);
    chkb("bb_no_dup",  a_ram_en, 1'b0);
    mem_addr = 9'h024;
    tick();
    chkb("bb_en1",     a_ram_en, 1'b1);
    chk ("bb_addr1",   32'(a_ram_addr), 32'h024);
    tick();
    chkb("bb_ready1",  a_mem_ready, 1'b1);
    chk ("bb_rdata1",  a_mem_rdata, 32'h2222_2222);
    tick();
    mem_req = 1'b0;

    // Reset during BUSY of a load aborts it
    mem_req  = 1'b1;
    mem_addr = 9'h020;
    tick();
    chkb("ra_en_busy", a_ram_en, 1'b1);
    reset_n = 1'b0;
    #1;
    chkb("ra_en",      a_ram_en, 1'b0);
    chk ("ra_addr",    32'(a_ram_addr), 32'h0);
    chk ("ra_mrdata",  a_mem_rdata, 32'h0);
    chk ("ra_irdata",  a_if_rdata, 32'h0);
    chkb("ra_mstall",  a_mem_stall, 1'b1);
    tick();
    chkb("ra_ready",   a_mem_ready, 1'b0);
    tick();
    chkb("ra_ready2",  a_mem_ready, 1'b0);
    reset_n = 1'b1;
    tick();
    chkb("ra_regrant", a_ram_en, 1'b1);
    chk ("ra_addr2",   32'(a_ram_addr), 32'h020);
    tick();
    chkb("ra_ready3",  a_mem_ready, 1'b1);
    chk ("ra_rdata",   a_mem_rdata, 32'h1111_1111);
    tick();
    mem_req = 1'b0;

    // WAIT_CYCLES=3 instance: latched address, then MEM grant after IF
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    if_req  = 1'b1;
    if_addr = 9'h004;
    tick();
    chkb("w3_en_t1",   b_ram_en, 1'b1);
    chk ("w3_addr_t1", 32'(b_ram_addr), 32'h004);
    tick();
    chkb("w3_en_t2",   b_ram_en, 1'b1);
    if_addr  = 9'h008;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 9'h010;
    tick();
    chk ("w3_addr_t3", 32'(b_ram_addr), 32'h004);
    chkb("w3_ready_t3", b_if_ready, 1'b0);
    tick();
    chkb("w3_ready_t4", b_if_ready, 1'b1);
    chk ("w3_rdata",   b_if_rdata, 32'h8C22_0000);
    chkb("w3_en_t4",   b_ram_en, 1'b0);
    tick();
    chkb("w3_en_t5",   b_ram_en, 1'b0);
    if_req = 1'b0;
    tick();
    chkb("w3_en_t6",   b_ram_en, 1'b1);
    chk ("w3_addr_t6", 32'(b_ram_addr), 32'h010);
    tick();
    tick();
    chkb("w3_mready_t8", b_mem_ready, 1'b0);
    tick();
    chkb("w3_mready_t9", b_mem_ready, 1'b1);
    chk ("w3_mrdata",  b_mem_rdata, 32'hDEAD_BEEF);
    mem_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
